// File: rtl/signed_seq_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, one restoring step
// per cycle on operand magnitudes, with truncating sign correction in a final FIX cycle.
module signed_seq_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  q_reg;
  logic [N-1:0]  m_reg;
  logic [N:0]    r_reg;
  logic [CW-1:0] cnt;
  logic          sq, sr, dz_pend, ovf_pend;

  logic [W-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
  logic          dvs_zero, ovf_case;
  logic [N+1:0]  r_sh, t;

  assign dvd_mag  = dividend[W-1] ? -dividend : dividend;
  assign dvs_mag  = divisor[N-1] ? -divisor : divisor;
  assign dvs_zero = (divisor == '0);
  assign ovf_case = (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);

  // Trial subtraction one bit wider than R so the borrow lands in t[N+1].
  assign r_sh = {r_reg, q_reg[W-1]};
  assign t    = r_sh - {2'b00, m_reg};

  // busy stays up through the done cycle, which already sits in IDLE.
  assign busy = (state_q != IDLE) || done;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = dvs_zero ? FIX : CALC;
      CALC:    if (cnt == CW'(W - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      m_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      dz_pend     <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            q_reg    <= dvd_mag;
            m_reg    <= dvs_mag;
            r_reg    <= '0;
            cnt      <= '0;
            sq       <= dividend[W-1] ^ divisor[N-1];
            sr       <= dividend[W-1];
            dz_pend  <= dvs_zero;
            ovf_pend <= ovf_case;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!t[N+1]) begin
            r_reg <= t[N:0];
            q_reg <= {q_reg[W-2:0], 1'b1};
          end else begin
            r_reg <= r_sh[N:0];
            q_reg <= {q_reg[W-2:0], 1'b0};
          end
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz_pend;
          overflow    <= ovf_pend;
          if (dz_pend) begin
            quotient  <= '0;
            remainder <= '0;
          end else begin
            // In the overflow case sq is 0, so the 2^(W-1) magnitude passes through and wraps.
            quotient  <= sq ? -q_reg : q_reg;
            remainder <= sr ? -r_reg[N-1:0] : r_reg[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider: directed cases, handshake corner cases
// and randomized operands compared against a plain-integer truncating division model.
module tb_signed_seq_divider;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [N-1:0] divisor;
  logic [W-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy, done, div_by_zero, overflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  signed_seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  // Reference: truncating integer division in 32-bit ints, then wrapped to port widths.
  function automatic void model(input logic [W-1:0] dvd, input logic [N-1:0] dvs,
                                output logic [W-1:0] eq, output logic [N-1:0] er,
                                output logic edz, output logic eov, output int elat);
    int a, b;
    a = int'($signed(dvd));
    b = int'($signed(dvs));
    if (b == 0) begin
      eq = '0; er = '0; edz = 1'b1; eov = 1'b0; elat = 1;
    end else begin
      eq   = W'(a / b);
      er   = N'(a % b);
      edz  = 1'b0;
      eov  = (a == -(2 ** (W - 1))) && (b == -1);
      elat = W + 1;
    end
  endfunction

  // Issues one operation and returns what the DUT produced; lat = edges from accept to done.
  task automatic do_op(input logic [W-1:0] dvd, input logic [N-1:0] dvs,
                       output logic [W-1:0] q, output logic [N-1:0] r,
                       output logic dz, output logic ov, output int lat, output logic clean);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = N'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 40) lat = -1;
    q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
    clean = (busy === 1'b1);
    @(negedge clk);
    clean = clean && (done === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    vectors++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: q=%h r=%h busy=%b done=%b dz=%b ov=%b, expected all 0",
               quotient, remainder, busy, done, div_by_zero, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] dvds [8] = '{8'd100, -8'sd100, 8'd100, -8'sd100, 8'h80, 8'h80, 8'd6, 8'd55};
    logic [N-1:0] dvss [8] = '{4'd7, 4'd7, -4'sd7, -4'sd7, 4'h8, 4'hf, 4'd3, 4'd0};
    int           eqs  [8] = '{14, -14, -14, 14, 16, -128, 2, 0};
    int           ers  [8] = '{2, -2, 2, -2, 0, 0, 0, 0};
    logic         edzs [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic         eovs [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int           elats[8] = '{9, 9, 9, 9, 9, 9, 9, 1};
    logic [W-1:0] q; logic [N-1:0] r; logic dz, ov, clean; int lat;
    for (int i = 0; i < 8; i++) begin
      do_op(dvds[i], dvss[i], q, r, dz, ov, lat, clean);
      vectors++;
      if (q !== W'(eqs[i]) || r !== N'(ers[i]) || dz !== edzs[i] || ov !== eovs[i] ||
          lat !== elats[i] || clean !== 1'b1) begin
        miscompares++;
        $display("FAIL directed[%0d] %0d/%0d: got q=%h r=%h dz=%b ov=%b lat=%0d clean=%b, expected q=%h r=%h dz=%b ov=%b lat=%0d clean=1",
                 i, $signed(dvds[i]), $signed(dvss[i]), q, r, dz, ov, lat, clean,
                 W'(eqs[i]), N'(ers[i]), edzs[i], eovs[i], elats[i]);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (div_by_zero !== 1'b1 || quotient !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flag_hold: dz=%b q=%h busy=%b, expected dz=1 q=00 busy=0",
               div_by_zero, quotient, busy);
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    logic [W-1:0] q = '0; logic [N-1:0] r = '0;
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 8'd5; divisor = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++; q = quotient; r = remainder;
      end
    end
    vectors++;
    if (dones !== 1 || q !== 8'd14 || r !== 4'd2) begin
      miscompares++;
      $display("FAIL ignore_start: dones=%0d q=%h r=%h, expected dones=1 q=0e r=2", dones, q, r);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    logic [W-1:0] q; logic [N-1:0] r; logic dz, ov, clean; int lat;
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: q=%h r=%h busy=%b done=%b dz=%b ov=%b, expected all 0",
               quotient, remainder, busy, done, div_by_zero, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abandon: dones=%0d busy=%b, expected dones=0 busy=0", dones, busy);
    end
    do_op(8'd127, -4'sd8, q, r, dz, ov, lat, clean);
    vectors++;
    if (q !== -8'sd15 || r !== 4'd7 || dz !== 1'b0 || ov !== 1'b0 || lat !== 9) begin
      miscompares++;
      $display("FAIL after_reset 127/-8: q=%h r=%h dz=%b ov=%b lat=%0d, expected q=f1 r=7 dz=0 ov=0 lat=9",
               q, r, dz, ov, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a_dvd = 8'd77, b_dvd = -8'sd93;
    logic [N-1:0] a_dvs = -4'sd5, b_dvs = 4'd6;
    logic [W-1:0] eqa, eqb; logic [N-1:0] era, erb; logic edz, eov; int elat;
    int           edge_seen [2] = '{-1, -1};
    logic [W-1:0] qs [2];
    logic [N-1:0] rs [2];
    int           k = 0;
    model(a_dvd, a_dvs, eqa, era, edz, eov, elat);
    model(b_dvd, b_dvs, eqb, erb, edz, eov, elat);
    @(negedge clk);
    dividend = a_dvd; divisor = a_dvs; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = b_dvd; divisor = b_dvs;
    for (int e = 1; e <= 30 && k < 2; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        edge_seen[k] = e; qs[k] = quotient; rs[k] = remainder; k++;
        if (k == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    vectors++;
    if (edge_seen[0] !== 9 || qs[0] !== eqa || rs[0] !== era) begin
      miscompares++;
      $display("FAIL b2b_first: edge=%0d q=%h r=%h, expected edge=9 q=%h r=%h",
               edge_seen[0], qs[0], rs[0], eqa, era);
    end
    vectors++;
    if (edge_seen[1] !== 2 * W + 3 || qs[1] !== eqb || rs[1] !== erb) begin
      miscompares++;
      $display("FAIL b2b_second: edge=%0d q=%h r=%h, expected edge=%0d q=%h r=%h",
               edge_seen[1], qs[1], rs[1], 2 * W + 3, eqb, erb);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] dvd, q, eq; logic [N-1:0] dvs, r, er;
    logic dz, ov, clean, edz, eov; int lat, elat;
    for (int i = 0; i < 60; i++) begin
      dvd = W'($urandom);
      dvs = N'($urandom);
      if (i % 10 == 3) dvd = {1'b1, {(W-1){1'b0}}};
      if (i % 10 == 4) dvs = '1;
      model(dvd, dvs, eq, er, edz, eov, elat);
      do_op(dvd, dvs, q, r, dz, ov, lat, clean);
      vectors++;
      if (q !== eq || r !== er || dz !== edz || ov !== eov || lat !== elat || clean !== 1'b1) begin
        miscompares++;
        $display("FAIL random[%0d] %0d/%0d: got q=%h r=%h dz=%b ov=%b lat=%0d clean=%b, expected q=%h r=%h dz=%b ov=%b lat=%0d clean=1",
                 i, $signed(dvd), $signed(dvs), q, r, dz, ov, lat, clean, eq, er, edz, eov, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
